// File: rtl/lc3_fetch_pkg.sv
// Shared types and constants for the LC-3 instruction fetch stage.
package lc3_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_INC  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_e;

  localparam logic [15:0] PC_RESET = 16'h3000;
  localparam logic [3:0]  TIMEOUT  = 4'd15;

  // 16-bit modulo increment; 16'hFFFF wraps to 16'h0000.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc_v);
    return pc_v + 16'd1;
  endfunction

endpackage

// File: rtl/lc3_pc_unit.sv
// Fetch program counter register with its hold / increment / branch-load mux.
module lc3_pc_unit
  import lc3_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  pc_sel_e     pc_sel_i,
  input  logic [15:0] taddr_i,
  output logic [15:0] pc_o
);

  logic [15:0] pc_q;
  logic [15:0] pc_d;

  // Next-PC selection.
  always_comb begin
    pc_d = pc_q;
    case (pc_sel_i)
      PC_HOLD: pc_d = pc_q;
      PC_INC:  pc_d = pc_inc(pc_q);
      PC_LOAD: pc_d = taddr_i;
      default: pc_d = pc_q;
    endcase
  end

  // PC register, restarts at the boot vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/lc3_fetch_stage.sv
// LC-3 fetch stage: IDLE/REQ/VALID handshake with instruction memory,
// branch redirect with squash of in-flight reads, and sticky request timeout.
module lc3_fetch_stage
  import lc3_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_fetch,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [15:0] taddr,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_rdata,
  output logic [15:0] pc,
  output logic [15:0] instr_dout,
  output logic [15:0] npc_out,
  output logic        enable_decode,
  output logic        imem_err
);

  fetch_state_e state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic         squash_q, squash_d;
  logic [15:0]  instr_q, instr_d;
  logic [15:0]  npc_q, npc_d;
  logic         en_dec_q, en_dec_d;
  logic         err_q, err_d;
  logic         req_q, req_d;
  pc_sel_e      pc_sel_s;
  logic [15:0]  pc_s;

  lc3_pc_unit u_pc_unit (
    .clk      (clk),
    .rst      (rst),
    .pc_sel_i (pc_sel_s),
    .taddr_i  (taddr),
    .pc_o     (pc_s)
  );

  // Next-state and registered-output logic; br_taken outranks stall and ack.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    en_dec_d = en_dec_q;
    err_d    = err_q;
    pc_sel_s = PC_HOLD;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 4'd0;
        if (br_taken) begin
          pc_sel_s = PC_LOAD;
        end else begin
          pc_sel_s = PC_HOLD;
        end
        if (enable_fetch) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (br_taken) begin
          // An un-acked read is still outstanding at the old PC; drop its data later.
          pc_sel_s = PC_LOAD;
          cnt_d    = 4'd0;
          squash_d = ~imem_ack;
        end else if (imem_ack) begin
          cnt_d = 4'd0;
          if (squash_q) begin
            squash_d = 1'b0;
          end else begin
            pc_sel_s = PC_INC;
            instr_d  = imem_rdata;
            npc_d    = pc_inc(pc_s);
            en_dec_d = 1'b1;
            state_d  = ST_VALID;
          end
        end else if ((cnt_q + 4'd1) == TIMEOUT) begin
          err_d    = 1'b1;
          cnt_d    = 4'd0;
          squash_d = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_VALID: begin
        cnt_d = 4'd0;
        if (br_taken || !stall) begin
          if (br_taken) begin
            pc_sel_s = PC_LOAD;
          end else begin
            pc_sel_s = PC_HOLD;
          end
          en_dec_d = 1'b0;
          if (enable_fetch) begin
            state_d = ST_REQ;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_VALID;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = 4'd0;
        squash_d = 1'b0;
        en_dec_d = 1'b0;
      end
    endcase
    req_d = (state_d == ST_REQ);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      squash_q <= 1'b0;
      instr_q  <= 16'h0000;
      npc_q    <= 16'h0000;
      en_dec_q <= 1'b0;
      err_q    <= 1'b0;
      req_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      en_dec_q <= en_dec_d;
      err_q    <= err_d;
      req_q    <= req_d;
    end
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_s;
  assign pc            = pc_s;
  assign instr_dout    = instr_q;
  assign npc_out       = npc_q;
  assign enable_decode = en_dec_q;
  assign imem_err      = err_q;

endmodule

// File: tb/tb_lc3_fetch_stage.sv
// Directed-vector bench for lc3_fetch_stage with hand-computed expectations.
module tb_lc3_fetch_stage;

  logic        clk;
  logic        rst;
  logic        enable_fetch;
  logic        stall;
  logic        br_taken;
  logic [15:0] taddr;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] pc;
  logic [15:0] instr_dout;
  logic [15:0] npc_out;
  logic        enable_decode;
  logic        imem_err;

  int vectors;
  int miscompares;

  lc3_fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .enable_fetch  (enable_fetch),
    .stall         (stall),
    .br_taken      (br_taken),
    .taddr         (taddr),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc            (pc),
    .instr_dout    (instr_dout),
    .npc_out       (npc_out),
    .enable_decode (enable_decode),
    .imem_err      (imem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    enable_fetch = 1'b0;
    stall        = 1'b0;
    br_taken     = 1'b0;
    taddr        = 16'h0000;
    imem_ack     = 1'b0;
    imem_rdata   = 16'h0000;
    step();
    step();
    chk("rst_pc", pc, 16'h3000);
    chk("rst_addr", imem_addr, 16'h3000);
    chk("rst_instr", instr_dout, 16'h0000);
    chk("rst_npc", npc_out, 16'h0000);
    chk("rst_en", {15'd0, enable_decode}, 16'd0);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_err", {15'd0, imem_err}, 16'd0);

    // First fetch at boot vector, ack two cycles into REQ.
    rst          = 1'b0;
    enable_fetch = 1'b1;
    step();
    chk("f1_req", {15'd0, imem_req}, 16'd1);
    chk("f1_addr", imem_addr, 16'h3000);
    step();
    chk("f1_req_hold", {15'd0, imem_req}, 16'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'h1021;
    step();
    imem_ack   = 1'b0;
    chk("f1_instr", instr_dout, 16'h1021);
    chk("f1_npc", npc_out, 16'h3001);
    chk("f1_en", {15'd0, enable_decode}, 16'd1);
    chk("f1_req_low", {15'd0, imem_req}, 16'd0);

    // Stall holds the presented instruction with no request.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stl_instr", instr_dout, 16'h1021);
      chk("stl_npc", npc_out, 16'h3001);
      chk("stl_en", {15'd0, enable_decode}, 16'd1);
      chk("stl_req", {15'd0, imem_req}, 16'd0);
    end
    stall = 1'b0;
    step();
    chk("unstl_en", {15'd0, enable_decode}, 16'd0);
    chk("unstl_req", {15'd0, imem_req}, 16'd1);
    chk("unstl_addr", imem_addr, 16'h3001);

    // Branch while a read is outstanding: the next ack is squashed.
    br_taken = 1'b1;
    taddr    = 16'h4000;
    step();
    br_taken = 1'b0;
    chk("sq_pc", pc, 16'h4000);
    chk("sq_req", {15'd0, imem_req}, 16'd1);
    step();
    imem_ack   = 1'b1;
    imem_rdata = 16'hDEAD;
    step();
    chk("sq_en", {15'd0, enable_decode}, 16'd0);
    chk("sq_instr", instr_dout, 16'h1021);
    chk("sq_req2", {15'd0, imem_req}, 16'd1);
    chk("sq_addr", imem_addr, 16'h4000);
    imem_rdata = 16'h1234;
    step();
    imem_ack = 1'b0;
    chk("sq_ok_instr", instr_dout, 16'h1234);
    chk("sq_ok_npc", npc_out, 16'h4001);
    chk("sq_ok_en", {15'd0, enable_decode}, 16'd1);

    // Branch coincident with ack: data dropped, no squash left behind.
    step();
    chk("ba_req", {15'd0, imem_req}, 16'd1);
    br_taken   = 1'b1;
    taddr      = 16'h5000;
    imem_ack   = 1'b1;
    imem_rdata = 16'hBEEF;
    step();
    br_taken = 1'b0;
    chk("ba_en", {15'd0, enable_decode}, 16'd0);
    chk("ba_pc", pc, 16'h5000);
    chk("ba_req2", {15'd0, imem_req}, 16'd1);
    imem_rdata = 16'h5555;
    step();
    imem_ack = 1'b0;
    chk("ba_instr", instr_dout, 16'h5555);
    chk("ba_npc", npc_out, 16'h5001);
    chk("ba_en2", {15'd0, enable_decode}, 16'd1);

    // Branch beats stall in VALID, then fetch at 16'hFFFF wraps.
    stall    = 1'b1;
    br_taken = 1'b1;
    taddr    = 16'hFFFF;
    step();
    br_taken = 1'b0;
    stall    = 1'b0;
    chk("wr_en", {15'd0, enable_decode}, 16'd0);
    chk("wr_addr", imem_addr, 16'hFFFF);
    chk("wr_req", {15'd0, imem_req}, 16'd1);
    imem_ack   = 1'b1;
    imem_rdata = 16'h0ABC;
    step();
    imem_ack = 1'b0;
    chk("wr_npc", npc_out, 16'h0000);
    chk("wr_instr", instr_dout, 16'h0ABC);
    step();
    chk("wr_next_addr", imem_addr, 16'h0000);
    chk("wr_next_req", {15'd0, imem_req}, 16'd1);

    // Timeout: enable_fetch dropped does not cancel; 15 un-acked REQ cycles.
    enable_fetch = 1'b0;
    for (int i = 1; i < 15; i++) begin
      step();
      chk("to_req_hold", {15'd0, imem_req}, 16'd1);
    end
    step();
    chk("to_err", {15'd0, imem_err}, 16'd1);
    chk("to_req", {15'd0, imem_req}, 16'd0);
    chk("to_pc", pc, 16'h0000);
    step();
    step();
    chk("to_idle_req", {15'd0, imem_req}, 16'd0);
    chk("to_sticky", {15'd0, imem_err}, 16'd1);
    enable_fetch = 1'b1;
    step();
    chk("to_refetch", {15'd0, imem_req}, 16'd1);
    chk("to_sticky2", {15'd0, imem_err}, 16'd1);

    // Asynchronous reset mid-REQ.
    #2;
    rst = 1'b1;
    #1;
    chk("ar_req", {15'd0, imem_req}, 16'd0);
    chk("ar_err", {15'd0, imem_err}, 16'd0);
    chk("ar_pc", pc, 16'h3000);
    chk("ar_instr", instr_dout, 16'h0000);
    chk("ar_npc", npc_out, 16'h0000);
    chk("ar_en", {15'd0, enable_decode}, 16'd0);

    // Late ack after release is ignored in IDLE; next fetch at boot vector.
    step();
    enable_fetch = 1'b0;
    imem_ack     = 1'b1;
    imem_rdata   = 16'h7777;
    rst          = 1'b0;
    step();
    chk("late_en", {15'd0, enable_decode}, 16'd0);
    chk("late_instr", instr_dout, 16'h0000);
    chk("late_pc", pc, 16'h3000);
    imem_ack     = 1'b0;
    enable_fetch = 1'b1;
    step();
    chk("boot_req", {15'd0, imem_req}, 16'd1);
    chk("boot_addr", imem_addr, 16'h3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
